cdc_in_arbiter: RTL and testbench

Round-robin arbiter that shares the single USB CDC bulk IN byte channel (`in_data`/`in_valid`/`in_ready` of `usb_cdc`) between several on-chip byte sources. Grants are burst-locked so one source's bytes stay contiguous within a bulk packet. The block sits between application logic (loopback, status reporters, debug streams) and the `usb_cdc` IN interface, in the same clock domain as `usb_cdc`'s application side.

---
 rtl/cdc_in_arbiter.sv | 134 +++++++++++++
 tb/tb_cdc_in_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_in_arbiter.sv
// rtl/cdc_in_arbiter.sv - burst-locked round-robin arbiter feeding the USB CDC bulk IN byte channel
module cdc_in_arbiter #(
    parameter int N_SRC       = 2,
    parameter int BURST_LEN   = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [8*N_SRC-1:0] src_data_i,
    input  logic [N_SRC-1:0]   src_valid_i,
    input  logic [N_SRC-1:0]   src_last_i,
    output logic [N_SRC-1:0]   src_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic [N_SRC-1:0]   grant_o
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [PW-1:0]    last_ptr_q, last_ptr_d;
    logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [HW-1:0]    idle_cnt_q, idle_cnt_d;

    logic             gnt_valid;
    logic             gnt_last;
    logic [7:0]       gnt_data;
    logic             xfer;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand;

    // grant_q is zero outside GRANT, so the one-hot mux also yields the idle outputs
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_q[k]) begin
                gnt_valid = gnt_valid | src_valid_i[k];
                gnt_last  = gnt_last | src_last_i[k];
                gnt_data  = gnt_data | src_data_i[8*k +: 8];
            end
        end
    end

    assign xfer        = gnt_valid & in_ready_i;
    assign in_valid_o  = gnt_valid;
    assign in_data_o   = gnt_data;
    assign src_ready_o = grant_q & {N_SRC{in_ready_i}};
    assign grant_o     = grant_q;

    // Scan starts just after the previous owner, giving every other requester a turn first
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = PW'((int'(last_ptr_q) + i) % N_SRC);
            if (!pick_found && src_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    grant_d    = N_SRC'(1) << pick_idx;
                    last_ptr_d = pick_idx;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (xfer && byte_cnt_q != BW'(BURST_LEN)) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                if (gnt_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != HW'(HOLD_CYCLES)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if ((xfer && (gnt_last || byte_cnt_d == BW'(BURST_LEN))) ||
                    idle_cnt_d == HW'(HOLD_CYCLES)) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_ptr_q <= PW'(N_SRC - 1);
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// tb/tb_cdc_in_arbiter.sv - scoreboard bench for cdc_in_arbiter with four sources
module tb_cdc_in_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [31:0] src_data_i;
    logic [3:0]  src_valid_i;
    logic [3:0]  src_last_i;
    logic [3:0]  src_ready_o;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i;
    logic [3:0]  grant_o;

    cdc_in_arbiter #(
        .N_SRC      (4),
        .BURST_LEN  (8),
        .HOLD_CYCLES(16)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .src_data_i (src_data_i),
        .src_valid_i(src_valid_i),
        .src_last_i (src_last_i),
        .src_ready_o(src_ready_o),
        .in_data_o  (in_data_o),
        .in_valid_o (in_valid_o),
        .in_ready_i (in_ready_i),
        .grant_o    (grant_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  sq [4][$];
    logic [9:0]  exp_q [$];
    logic [3:0]  hs_pend = '0;
    logic [8:0]  drv_head;
    logic        toggle_mode = 1'b0;
    logic        track_ready = 1'b0;
    int          cyc = 0;
    int          nx = 0;
    int          xfer_cyc [0:255];
    logic [3:0]  grant_hist [0:4095];
    logic [1:0]  mon_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic push_src(input int s, input int n, input int base, input bit last_end);
        for (int i = 0; i < n; i++) sq[s].push_back({(last_end && i == n - 1), 8'(base + i)});
    endtask

    task automatic push_exp(input int s, input int n, input int base);
        for (int i = 0; i < n; i++) exp_q.push_back({2'(s), 8'(base + i)});
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(negedge clk); #1;
            b++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int b;
        b = 0;
        while (nx < target && b < budget) begin
            @(negedge clk); #1;
            b++;
        end
        check_eq("xfer_wait", (nx >= target), 1);
    endtask

    // Source models: present queue heads, retire a byte after an observed handshake
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs_pend[k] && sq[k].size() > 0) void'(sq[k].pop_front());
            if (sq[k].size() > 0) begin
                drv_head              = sq[k][0];
                src_valid_i[k]        = 1'b1;
                src_last_i[k]         = drv_head[8];
                src_data_i[8*k +: 8]  = drv_head[7:0];
            end else begin
                src_valid_i[k]        = 1'b0;
                src_last_i[k]         = 1'b0;
                src_data_i[8*k +: 8]  = 8'h00;
            end
        end
        in_ready_i = toggle_mode ? ~in_ready_i : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (cyc < 4096) grant_hist[cyc] = grant_o;
        hs_pend = src_valid_i & src_ready_o;
        if (track_ready && grant_o != 4'b0)
            check_eq("ready_track", src_ready_o, {4{in_ready_i}} & 4'b0100);
        if (in_valid_o && in_ready_i) begin
            mon_idx = oh2idx(grant_o);
            if (nx < 256) xfer_cyc[nx] = cyc;
            nx++;
            check_eq("unexp_xfer", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("xfer", {mon_idx, in_data_o}, exp_q.pop_front());
        end
    end

    int base;
    int c;

    initial begin
        rstn_i      = 1'b0;
        src_data_i  = '0;
        src_valid_i = '0;
        src_last_i  = '0;
        in_ready_i  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", grant_o, 0);
        check_eq("rst_valid", in_valid_o, 0);
        check_eq("rst_ready", src_ready_o, 0);
        check_eq("rst_data", in_data_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;

        // single source, 7 bytes, last on the seventh
        @(negedge clk); #1;
        base = nx;
        push_src(0, 7, 8'h01, 1);
        push_exp(0, 7, 8'h01);
        wait_done(200);
        check_eq("t1_count", nx - base, 7);
        check_eq("t1_contig", xfer_cyc[base + 6] - xfer_cyc[base], 6);
        check_eq("t1_grant_last", grant_hist[xfer_cyc[base + 6]], 4'b0001);
        check_eq("t1_release", grant_hist[xfer_cyc[base + 6] + 1], 4'b0000);
        check_eq("t1_idle", grant_hist[xfer_cyc[base + 6] + 2], 4'b0000);

        // source 1 stalls after 3 bytes; source 0 waits behind it
        base = nx;
        push_src(1, 3, 8'h30, 0);
        push_src(0, 2, 8'h38, 1);
        push_exp(1, 3, 8'h30);
        push_exp(0, 2, 8'h38);
        wait_done(200);
        c = xfer_cyc[base + 2];
        check_eq("t3_held", grant_hist[c + 16], 4'b0010);
        check_eq("t3_revoked", grant_hist[c + 17], 4'b0000);
        check_eq("t3_next_grant", xfer_cyc[base + 3], c + 19);

        // source 2 with in_ready toggling; burst cap at 8 bytes
        base = nx;
        toggle_mode = 1'b1;
        track_ready = 1'b1;
        push_src(2, 10, 8'h50, 1);
        push_exp(2, 10, 8'h50);
        wait_done(400);
        toggle_mode = 1'b0;
        track_ready = 1'b0;
        check_eq("t4_after7", grant_hist[xfer_cyc[base + 6] + 1], 4'b0100);
        check_eq("t4_after8", grant_hist[xfer_cyc[base + 7] + 1], 4'b0000);
        repeat (3) @(negedge clk);
        #1;

        // reset pulsed mid-burst; source 0 must win first afterwards
        base = nx;
        push_src(0, 8, 8'h40, 1);
        push_exp(0, 8, 8'h40);
        wait_xfers(base + 4, 100);
        @(posedge clk);
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("t5_grant", grant_o, 0);
        check_eq("t5_valid", in_valid_o, 0);
        check_eq("t5_ready", src_ready_o, 0);
        @(negedge clk); #1;
        push_src(1, 2, 8'h70, 1);
        push_exp(1, 2, 8'h70);
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        wait_done(200);
        check_eq("t5_count", nx - base, 10);

        // two sources with 16 bytes each alternate in 8-byte bursts
        base = nx;
        push_src(0, 16, 8'h80, 1);
        push_src(1, 16, 8'hA0, 1);
        for (int blk = 0; blk < 4; blk++) push_exp(blk % 2, 8, (blk % 2 ? 8'hA0 : 8'h80) + (blk / 2) * 8);
        wait_done(400);
        check_eq("t2_burst", xfer_cyc[base + 7] - xfer_cyc[base], 7);
        for (int s = 1; s < 4; s++)
            check_eq("t2_gap", xfer_cyc[base + 8*s] - xfer_cyc[base + 8*s - 1], 3);

        // all four sources request together after reset
        @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk); #1;
        push_src(0, 1, 8'h60, 1);
        push_src(0, 1, 8'h64, 1);
        push_src(1, 1, 8'h61, 1);
        push_src(2, 1, 8'h62, 1);
        push_src(3, 1, 8'h63, 1);
        push_exp(0, 1, 8'h60);
        push_exp(1, 1, 8'h61);
        push_exp(2, 1, 8'h62);
        push_exp(3, 1, 8'h63);
        push_exp(0, 1, 8'h64);
        @(negedge clk);
        rstn_i = 1'b1;
        wait_done(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
